// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - byte-wide RAM port sequencer for instruction fetch and load/store buffer
module mem_arbiter #(
    parameter logic [1:0] IO_HI = 2'b11
) (
    input  logic        clockIn,
    input  logic        resetIn,
    input  logic        readyIn,
    input  logic        clearIn,
    input  logic        ioBufferFull,
    input  logic        lsbFlag,
    input  logic [2:0]  lsbOp,
    input  logic [31:0] lsbAddr,
    input  logic [31:0] lsbDataIn,
    output logic [31:0] lsbData,
    output logic        lsbOk,
    input  logic        ifFlag,
    input  logic [31:0] ifAddr,
    output logic [31:0] ifData,
    output logic        ifOk,
    input  logic [7:0]  ramIn,
    output logic [7:0]  ramOut,
    output logic [31:0] ramAddr,
    output logic        ramWr
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]  state_q,    state_d;
    logic        owner_lsb_q, owner_lsb_d;
    logic [31:0] base_q,     base_d;
    logic [31:0] wdata_q,    wdata_d;
    logic [2:0]  nbytes_q,   nbytes_d;
    logic [2:0]  cnt_q,      cnt_d;
    logic [31:0] rd_buf_q,   rd_buf_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic [7:0]  ram_out_q,  ram_out_d;
    logic        ram_wr_q,   ram_wr_d;
    logic        lsb_ok_q,   lsb_ok_d;
    logic        if_ok_q,    if_ok_d;
    logic [31:0] lsb_data_q, lsb_data_d;
    logic [31:0] if_data_q,  if_data_d;

    logic        io_stall;
    logic [2:0]  cnt_next;
    logic [1:0]  lane_next;
    logic [31:0] rd_buf_cap;

    // I/O writes stall on the byte currently presented to the port
    assign io_stall  = (state_q == S_WRITE) && (ram_addr_q[17:16] == IO_HI) && ioBufferFull;
    assign cnt_next  = cnt_q + 3'd1;
    assign lane_next = cnt_next[1:0];

    // READ cycle c (c >= 1) sees the byte addressed in cycle c-1
    always_comb begin
        rd_buf_cap = rd_buf_q;
        case (cnt_q)
            3'd1:    rd_buf_cap[7:0]   = ramIn;
            3'd2:    rd_buf_cap[15:8]  = ramIn;
            3'd3:    rd_buf_cap[23:16] = ramIn;
            3'd4:    rd_buf_cap[31:24] = ramIn;
            default: rd_buf_cap = rd_buf_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        owner_lsb_d = owner_lsb_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        nbytes_d    = nbytes_q;
        cnt_d       = cnt_q;
        rd_buf_d    = rd_buf_q;
        ram_addr_d  = ram_addr_q;
        ram_out_d   = ram_out_q;
        ram_wr_d    = ram_wr_q;
        lsb_ok_d    = lsb_ok_q;
        if_ok_d     = if_ok_q;
        lsb_data_d  = lsb_data_q;
        if_data_d   = if_data_q;

        if (readyIn) begin
            case (state_q)
                S_IDLE: begin
                    if (lsbFlag) begin
                        owner_lsb_d = 1'b1;
                        base_d      = lsbAddr;
                        wdata_d     = lsbDataIn;
                        cnt_d       = 3'd0;
                        rd_buf_d    = 32'd0;
                        ram_addr_d  = lsbAddr;
                        case (lsbOp[1:0])
                            2'b00:   nbytes_d = 3'd1;
                            2'b01:   nbytes_d = 3'd2;
                            default: nbytes_d = 3'd4;
                        endcase
                        if (lsbOp[2]) begin
                            state_d   = S_WRITE;
                            ram_out_d = lsbDataIn[7:0];
                            ram_wr_d  = 1'b1;
                        end else begin
                            state_d   = S_READ;
                        end
                    end else if (ifFlag) begin
                        owner_lsb_d = 1'b0;
                        base_d      = ifAddr;
                        nbytes_d    = 3'd4;
                        cnt_d       = 3'd0;
                        rd_buf_d    = 32'd0;
                        ram_addr_d  = ifAddr;
                        state_d     = S_READ;
                    end
                end
                S_READ: begin
                    if (clearIn) begin
                        state_d  = S_IDLE;
                        ram_wr_d = 1'b0;
                    end else begin
                        rd_buf_d = rd_buf_cap;
                        cnt_d    = cnt_next;
                        if (cnt_next < nbytes_q) begin
                            ram_addr_d = base_q + {29'd0, cnt_next};
                        end
                        if (cnt_q == nbytes_q) begin
                            state_d = S_DONE;
                            if (owner_lsb_q) begin
                                lsb_data_d = rd_buf_cap;
                                lsb_ok_d   = 1'b1;
                            end else begin
                                if_data_d  = rd_buf_cap;
                                if_ok_d    = 1'b1;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    // committed stores ignore clearIn and always finish
                    if (!io_stall) begin
                        if (cnt_next == nbytes_q) begin
                            state_d  = S_DONE;
                            ram_wr_d = 1'b0;
                            lsb_ok_d = 1'b1;
                        end else begin
                            cnt_d      = cnt_next;
                            ram_addr_d = base_q + {29'd0, cnt_next};
                            ram_out_d  = wdata_q[{lane_next, 3'b000} +: 8];
                        end
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    lsb_ok_d = 1'b0;
                    if_ok_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            state_q     <= S_IDLE;
            owner_lsb_q <= 1'b0;
            base_q      <= 32'd0;
            wdata_q     <= 32'd0;
            nbytes_q    <= 3'd0;
            cnt_q       <= 3'd0;
            rd_buf_q    <= 32'd0;
            ram_addr_q  <= 32'd0;
            ram_out_q   <= 8'd0;
            ram_wr_q    <= 1'b0;
            lsb_ok_q    <= 1'b0;
            if_ok_q     <= 1'b0;
            lsb_data_q  <= 32'd0;
            if_data_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            owner_lsb_q <= owner_lsb_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            nbytes_q    <= nbytes_d;
            cnt_q       <= cnt_d;
            rd_buf_q    <= rd_buf_d;
            ram_addr_q  <= ram_addr_d;
            ram_out_q   <= ram_out_d;
            ram_wr_q    <= ram_wr_d;
            lsb_ok_q    <= lsb_ok_d;
            if_ok_q     <= if_ok_d;
            lsb_data_q  <= lsb_data_d;
            if_data_q   <= if_data_d;
        end
    end

    assign ramAddr = ram_addr_q;
    assign ramOut  = ram_out_q;
    assign ramWr   = ram_wr_q & readyIn & ~io_stall;
    assign lsbOk   = lsb_ok_q;
    assign ifOk    = if_ok_q;
    assign lsbData = lsb_data_q;
    assign ifData  = if_data_q;

endmodule
